// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between two L1 clients: port 0 is the
//   I-cache and port 1 is the D-cache. Grants are registered and round-robin.
//   A grant is held for the whole burst, so a line fill is never interleaved
//   with the other client. A burst limit stops one client from starving the
//   other.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   rN_ce/rw/addr/wdata client N request (rw: 1 = read, 0 = write)
//   rN_rdata            read data; zero unless port N owns the memory port
//   rN_gnt              port N owns the memory port this cycle (registered)
//   mem_ce/rw/addr      memory control, muxed from the current owner
//   mem_data            bidirectional memory data bus
//   owner               debug: 00 none, 01 port 0, 10 port 1
module mem_port_arbiter #(
  parameter int MAX_BURST = 8,   // 1..15
  parameter int CNT_BITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_ce,
  input  logic        r0_rw,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic [31:0] r0_rdata,
  output logic        r0_gnt,
  input  logic        r1_ce,
  input  logic        r1_rw,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic [31:0] r1_rdata,
  output logic        r1_gnt,
  output logic        mem_ce,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic [1:0]  owner
);

  // Encoding doubles as the owner debug value.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_GNT0 = 2'b01,
    S_GNT1 = 2'b10
  } state_t;

  localparam logic [CNT_BITS-1:0] BMAX = CNT_BITS'(MAX_BURST);
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  state_t              state;
  logic                last;   // 0: port 0 granted most recently, 1: port 1
  logic [CNT_BITS-1:0] bcnt;   // granted cycles in the current burst
  logic                at_max;

  assign at_max = (bcnt == BMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= 1'b1;             // port 0 wins the first tie
      bcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Tie goes to the port that was not granted last.
          if (r0_ce && (!r1_ce || last)) begin
            state <= S_GNT0;
            last  <= 1'b0;
            bcnt  <= ONE;
          end else if (r1_ce) begin
            state <= S_GNT1;
            last  <= 1'b1;
            bcnt  <= ONE;
          end
        end
        S_GNT0: begin
          if (!r0_ce || (at_max && r1_ce)) begin
            // Hand over straight to a waiting port 1, no dead cycle.
            if (r1_ce) begin
              state <= S_GNT1;
              last  <= 1'b1;
              bcnt  <= ONE;
            end else begin
              state <= S_IDLE;
            end
          end else if (!at_max) begin
            bcnt <= bcnt + ONE;
          end
        end
        S_GNT1: begin
          if (!r1_ce || (at_max && r0_ce)) begin
            if (r0_ce) begin
              state <= S_GNT0;
              last  <= 1'b0;
              bcnt  <= ONE;
            end else begin
              state <= S_IDLE;
            end
          end else if (!at_max) begin
            bcnt <= bcnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign owner  = state;
  assign r0_gnt = (state == S_GNT0);
  assign r1_gnt = (state == S_GNT1);

  // Owner mux: purely combinational from the state register, so the arbiter
  // adds no latency to the memory access itself.
  logic [31:0] wdata_sel;

  always_comb begin
    mem_ce    = 1'b0;
    mem_rw    = 1'b1;
    mem_addr  = '0;
    wdata_sel = '0;
    if (r0_gnt) begin
      mem_ce    = r0_ce;
      mem_rw    = r0_rw;
      mem_addr  = r0_addr;
      wdata_sel = r0_wdata;
    end else if (r1_gnt) begin
      mem_ce    = r1_ce;
      mem_rw    = r1_rw;
      mem_addr  = r1_addr;
      wdata_sel = r1_wdata;
    end
  end

  // Bus is driven only for an active write; otherwise memory may drive it.
  assign mem_data = (mem_ce && !mem_rw) ? wdata_sel : 32'bz;

  assign r0_rdata = r0_gnt ? mem_data : 32'h0;
  assign r1_rdata = r1_gnt ? mem_data : 32'h0;

endmodule
